ps2_scan_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_line_filter.sv | 59 +++++
 rtl/ps2_scan_rx.sv | 153 +++++++++++++++
 tb/tb_ps2_scan_rx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and FSM encoding for the PS/2 scan-code receiver.
package ps2_pkg;
    localparam logic [7:0] IS_INIT    = 8'hAA;
    localparam logic [7:0] IS_EXTEND  = 8'hE0;
    localparam logic [7:0] IS_BREAK   = 8'hF0;
    localparam int         FRAME_BITS = 11;
    // start + parity + stop surround the payload
    localparam int         DATA_BITS  = FRAME_BITS - 3;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;
endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises both PS/2 lines, debounces PS2_CLK and emits a strobe on its filtered falling edge.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic PS2_CLK,
    input  logic PS2_DATA,
    output logic data_sync,
    output logic fall_strobe
);
    logic                  clk_meta_q, clk_meta_d;
    logic                  clk_sync_q, clk_sync_d;
    logic                  data_meta_q, data_meta_d;
    logic                  data_sync_q, data_sync_d;
    logic [FILTER_LEN-1:0] filt_sr_q, filt_sr_d;
    logic                  clk_filt_q, clk_filt_d;
    logic                  fall_q, fall_d;

    always_comb begin
        clk_meta_d  = PS2_CLK;
        clk_sync_d  = clk_meta_q;
        data_meta_d = PS2_DATA;
        data_sync_d = data_meta_q;
        filt_sr_d   = {filt_sr_q[FILTER_LEN-2:0], clk_sync_q};
        // Level only moves once the whole window agrees; anything mixed holds.
        clk_filt_d  = clk_filt_q;
        if (filt_sr_q == '0) begin
            clk_filt_d = 1'b0;
        end else if (&filt_sr_q) begin
            clk_filt_d = 1'b1;
        end
        fall_d = clk_filt_q & ~clk_filt_d;
    end

    // Idle-high preload keeps reset release from looking like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            filt_sr_q   <= '1;
            clk_filt_q  <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            filt_sr_q   <= filt_sr_d;
            clk_filt_q  <= clk_filt_d;
            fall_q      <= fall_d;
        end
    end

    assign data_sync   = data_sync_q;
    assign fall_strobe = fall_q;
endmodule

// File: rtl/ps2_scan_rx.sv
// Receive-only PS/2 frame receiver: deserialises 11-bit frames, checks parity/stop and flags prefixes.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int VALID_HOLD  = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DATA,
    output logic [7:0] key_in,
    output logic       is_extend,
    output logic       is_break,
    output logic       valid,
    output logic       err
);
    localparam int HOLD_W = $clog2(VALID_HOLD + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(VALID_HOLD);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic data_sync;
    logic fall_strobe;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk         (clk),
        .rst         (rst),
        .PS2_CLK     (PS2_CLK),
        .PS2_DATA    (PS2_DATA),
        .data_sync   (data_sync),
        .fall_strobe (fall_strobe)
    );

    ps2_state_e        state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        key_q, key_d;
    logic              ext_q, ext_d;
    logic              brk_q, brk_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        key_d     = key_q;
        ext_d     = 1'b0;
        brk_d     = 1'b0;
        err_d     = 1'b0;
        hold_d    = (hold_q != '0) ? hold_q - 1'b1 : '0;
        tmo_d     = '0;
        if (state_q != IDLE && !fall_strobe) begin
            tmo_d = tmo_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (fall_strobe && !data_sync) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fall_strobe) begin
                    shift_d   = {data_sync, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_strobe) begin
                    parity_d = data_sync;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall_strobe) begin
                    state_d = IDLE;
                    if ((^shift_q ^ parity_q) && data_sync) begin
                        key_d = shift_q;
                        if (shift_q == IS_EXTEND) begin
                            ext_d = 1'b1;
                        end else if (shift_q == IS_BREAK) begin
                            brk_d = 1'b1;
                        end else begin
                            hold_d = HOLD_LOAD;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase

        // A stalled partial frame is dropped; the next start bit begins afresh.
        if (state_q != IDLE && !fall_strobe && tmo_q == TMO_LAST) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
            tmo_d     = '0;
            err_d     = 1'b1;
        end

        valid_d = (hold_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tmo_q     <= '0;
            hold_q    <= '0;
            key_q     <= 8'h00;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tmo_q     <= tmo_d;
            hold_q    <= hold_d;
            key_q     <= key_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign key_in    = key_q;
    assign is_extend = ext_q;
    assign is_break  = brk_q;
    assign valid     = valid_q;
    assign err       = err_q;
endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed-frame bench for ps2_scan_rx: good frames, prefixes, bad parity/stop, timeout, glitches, reset.
module tb_ps2_scan_rx;
    localparam int FL   = 4;
    localparam int VH   = 4;
    localparam int TO   = 200;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk_drv = 1'b1;
    logic       ps2_data_drv = 1'b1;
    wire        ps2_clk_w;
    wire        ps2_data_w;
    logic [7:0] key_in;
    logic       is_extend, is_break, valid, err;

    assign ps2_clk_w  = ps2_clk_drv;
    assign ps2_data_w = ps2_data_drv;

    always #5 clk = ~clk;

    ps2_scan_rx #(
        .FILTER_LEN  (FL),
        .VALID_HOLD  (VH),
        .TIMEOUT_CYC (TO)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .PS2_CLK   (ps2_clk_w),
        .PS2_DATA  (ps2_data_w),
        .key_in    (key_in),
        .is_extend (is_extend),
        .is_break  (is_break),
        .valid     (valid),
        .err       (err)
    );

    // Output monitor, sampled on the falling system-clock edge.
    int         cyc = 0, last_strobe_cyc = 0, last_lat = 0;
    int         n_rise = 0, n_ext = 0, n_brk = 0, n_err = 0, n_unstable = 0;
    int         run = 0, last_run = 0;
    logic [7:0] key_at_rise = 8'h00;
    logic       valid_prev = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (u_dut.u_filter.fall_strobe) last_strobe_cyc <= cyc;
        if (is_extend) n_ext <= n_ext + 1;
        if (is_break)  n_brk <= n_brk + 1;
        if (err)       n_err <= n_err + 1;
        if (valid) begin
            if (!valid_prev) begin
                n_rise      <= n_rise + 1;
                key_at_rise <= key_in;
                run         <= 1;
                last_lat    <= cyc - last_strobe_cyc;
            end else begin
                run <= run + 1;
                if (key_in != key_at_rise) n_unstable <= n_unstable + 1;
            end
        end else if (valid_prev) begin
            last_run <= run;
        end
        valid_prev <= valid;
    end

    int n_vec = 0;
    int n_bad = 0;
    int s_rise, s_ext, s_brk, s_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_rise = n_rise;
        s_ext  = n_ext;
        s_brk  = n_brk;
        s_err  = n_err;
    endtask

    task automatic ps2_bit(input logic b);
        @(posedge clk); #1 ps2_data_drv = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk_drv = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk_drv = 1'b1;
    endtask

    task automatic ps2_frame(input logic [7:0] b, input logic par, input logic stp);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stp);
        ps2_data_drv = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_events(input string tag, input logic [7:0] exp_key,
                                 input int e_rise, input int e_ext, input int e_brk, input int e_err);
        chk({tag, ".key"},   32'(key_in), 32'(exp_key));
        chk({tag, ".valid"}, 32'(n_rise - s_rise), 32'(e_rise));
        chk({tag, ".ext"},   32'(n_ext - s_ext), 32'(e_ext));
        chk({tag, ".brk"},   32'(n_brk - s_brk), 32'(e_brk));
        chk({tag, ".err"},   32'(n_err - s_err), 32'(e_err));
        if (e_rise != 0) begin
            chk({tag, ".hold"}, 32'(last_run), 32'(VH));
            chk({tag, ".lat"},  32'(last_lat), 32'd1);
        end
        $display("txn %-10s key=%02h valid=%0d ext=%0d brk=%0d err=%0d", tag, key_in,
                 n_rise - s_rise, n_ext - s_ext, n_brk - s_brk, n_err - s_err);
    endtask

    task automatic send_and_check(input string tag, input logic [7:0] b, input logic par,
                                  input logic stp, input logic [7:0] exp_key,
                                  input int e_rise, input int e_ext, input int e_brk, input int e_err);
        snap();
        ps2_frame(b, par, stp);
        expect_events(tag, exp_key, e_rise, e_ext, e_brk, e_err);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst.key",   32'(key_in), 32'h00);
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.err",   32'(err), 32'd0);
        chk("rst.ext",   32'(is_extend), 32'd0);
        chk("rst.brk",   32'(is_break), 32'd0);
        snap();
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        expect_events("rst_rel", 8'h00, 0, 0, 0, 0);

        // Parity bits hand-computed for odd parity over data+parity.
        send_and_check("k1C",     8'h1C, 1'b0, 1'b1, 8'h1C, 1, 0, 0, 0);
        send_and_check("kE0",     8'hE0, 1'b0, 1'b1, 8'hE0, 0, 1, 0, 0);
        send_and_check("kF0",     8'hF0, 1'b1, 1'b1, 8'hF0, 0, 0, 1, 0);
        send_and_check("k75",     8'h75, 1'b0, 1'b1, 8'h75, 1, 0, 0, 0);
        send_and_check("bad_par", 8'h1C, 1'b1, 1'b1, 8'h75, 0, 0, 0, 1);
        send_and_check("bad_stp", 8'hAA, 1'b1, 1'b0, 8'h75, 0, 0, 0, 1);
        send_and_check("kAA",     8'hAA, 1'b1, 1'b1, 8'hAA, 1, 0, 0, 0);

        // Start bit plus three data bits, then the clock stalls high.
        snap();
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data_drv = 1'b1;
        repeat (250) @(posedge clk);
        @(negedge clk);
        expect_events("timeout", 8'hAA, 0, 0, 0, 1);
        send_and_check("k2D",     8'h2D, 1'b1, 1'b1, 8'h2D, 1, 0, 0, 0);

        // Short PS2_CLK glitches with data low would look like start bits if they leaked through.
        snap();
        @(posedge clk); #1 ps2_data_drv = 1'b0;
        for (int g = 0; g < 6; g++) begin
            @(posedge clk); #1 ps2_clk_drv = 1'b0;
            repeat ((g % 2) + 1) @(posedge clk);
            #1 ps2_clk_drv = 1'b1;
            repeat (10) @(posedge clk);
        end
        #1 ps2_data_drv = 1'b1;
        repeat (250) @(posedge clk);
        @(negedge clk);
        expect_events("glitch", 8'h2D, 0, 0, 0, 0);

        // Reset in the middle of a 0x2C frame.
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        @(posedge clk); #1 rst = 1'b1;
        ps2_clk_drv = 1'b1;
        ps2_data_drv = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_rst.key",   32'(key_in), 32'h00);
        chk("mid_rst.valid", 32'(valid), 32'd0);
        chk("mid_rst.err",   32'(err), 32'd0);
        snap();
        @(posedge clk); #1 rst = 1'b0;
        repeat (250) @(posedge clk);
        @(negedge clk);
        expect_events("rst_rel2", 8'h00, 0, 0, 0, 0);
        send_and_check("k2C",     8'h2C, 1'b0, 1'b1, 8'h2C, 1, 0, 0, 0);

        chk("key_stable", 32'(n_unstable), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
